// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: both requester handshakes plus the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_read_ce;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_fin;
  logic              d_read_ce;
  logic              d_write_ce;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_fin;
  logic              m_ce;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_fin;
  logic              grant_d;
  logic              err;

  modport slave (
    input  i_read_ce, i_addr, d_read_ce, d_write_ce, d_addr, d_wdata, m_rdata, m_fin,
    output i_rdata, i_fin, d_rdata, d_fin, m_ce, m_we, m_addr, m_wdata, grant_d, err
  );

  modport master (
    output i_read_ce, i_addr, d_read_ce, d_write_ce, d_addr, d_wdata, m_rdata, m_fin,
    input  i_rdata, i_fin, d_rdata, d_fin, m_ce, m_we, m_addr, m_wdata, grant_d, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store with ce/fin handshakes.
// Define ARB_RR_EN for round-robin on conflicts; default build gives data fixed priority.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | port free, sampling requests, winner latched on next edge
// S_GRANT_I | fetch access on the memory port, waiting for m_fin/timeout
// S_GRANT_D | load/store access on the memory port, waiting for m_fin/timeout
// S_RELEASE | fin pulse cycle, no new grant so the requester can drop ce
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              m_ce_q, m_ce_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_fin_q, i_fin_d;
  logic              d_fin_q, d_fin_d;
  logic              grant_d_q, grant_d_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
`ifdef ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  logic req_i, req_d, pick_d, done;

  always_comb begin
    req_i = bus.i_read_ce;
    req_d = bus.d_read_ce | bus.d_write_ce;
`ifdef ARB_RR_EN
    // On a conflict the side not served last wins
    pick_d = req_d & (~req_i | ~last_d_q);
`else
    pick_d = req_d;
`endif
    done = bus.m_fin | (cnt_q == TO_LAST);

    state_d   = state_q;
    m_ce_d    = m_ce_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_fin_d   = 1'b0;
    d_fin_d   = 1'b0;
    grant_d_d = grant_d_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
`ifdef ARB_RR_EN
    last_d_d  = last_d_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_i | req_d) begin
          m_ce_d    = 1'b1;
          cnt_d     = 8'd0;
          grant_d_d = pick_d;
          if (pick_d) begin
            state_d   = S_GRANT_D;
            m_we_d    = bus.d_write_ce;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end else begin
            state_d   = S_GRANT_I;
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
          end
`ifdef ARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (done) begin
          m_ce_d    = 1'b0;
          grant_d_d = 1'b0;
          state_d   = S_RELEASE;
          if (!bus.m_fin) err_d = 1'b1;
          if (state_q == S_GRANT_I) begin
            i_fin_d   = 1'b1;
            i_rdata_d = bus.m_fin ? bus.m_rdata : '0;
          end else begin
            d_fin_d = 1'b1;
            // Completed stores leave d_rdata alone; a timeout always zeroes it
            if (!bus.m_fin)   d_rdata_d = '0;
            else if (!m_we_q) d_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_ce_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_fin_q   <= 1'b0;
      d_fin_q   <= 1'b0;
      grant_d_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
`ifdef ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_ce_q    <= m_ce_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_fin_q   <= i_fin_d;
      d_fin_q   <= d_fin_d;
      grant_d_q <= grant_d_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  assign bus.m_ce    = m_ce_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_fin   = i_fin_q;
  assign bus.d_fin   = d_fin_q;
  assign bus.grant_d = grant_d_q;
  assign bus.err     = err_q;

endmodule
